// File: rtl/puf_soc_pkg.sv
// Shared types and defaults for the PUF response generator.
package puf_soc_pkg;

    localparam int unsigned CntBitSizeDef = 32;
    localparam int unsigned RespBitsDef   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StRun,
        StCmp,
        StOut
    } state_e;

    // Index width for n response bits, never below 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/puf_soc_edge_cap.sv
// Rising-edge detector plus count capture for one RO counter channel.
// cap_done/cap_val look ahead: they already reflect a capture happening this
// cycle, so the sequencer can leave RUN on the same edge the capture lands.
module puf_soc_edge_cap
    import puf_soc_pkg::*;
#(
    parameter int unsigned CNT_BIT_SIZE = CntBitSizeDef
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    arm,
    input  logic                    valid,
    input  logic [CNT_BIT_SIZE-1:0] cnt,
    output logic [CNT_BIT_SIZE-1:0] cap_val,
    output logic                    cap_done
);

    logic                    valid_q;
    logic                    done_q;
    logic [CNT_BIT_SIZE-1:0] val_q;
    logic                    edge_hit;

    // A valid already high when arming is not an edge: valid_q keeps tracking
    // outside RUN, so stale data from the previous bit is never taken.
    always_comb begin
        edge_hit = arm & valid & ~valid_q & ~done_q;
        cap_done = done_q | edge_hit;
        cap_val  = edge_hit ? cnt : val_q;
    end

    // Previous-valid tracking and first-edge capture, cleared per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            val_q   <= '0;
        end else begin
            valid_q <= valid;
            if (clr) begin
                done_q <= 1'b0;
                val_q  <= '0;
            end else if (edge_hit) begin
                done_q <= 1'b1;
                val_q  <= cnt;
            end
        end
    end

endmodule

// File: rtl/puf_soc_resp_gen.sv
// Sequences one RO-pair measurement per response bit and assembles the
// response word and instability mask for the SoC register interface.
module puf_soc_resp_gen
    import puf_soc_pkg::*;
#(
    parameter int unsigned CNT_BIT_SIZE = CntBitSizeDef,
    parameter int unsigned RESP_BITS    = RespBitsDef,
    parameter int unsigned SETTLE_CYC   = 4,
    parameter int unsigned TMO_W        = 24,
    localparam int unsigned IDX_W       = idx_width(RESP_BITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [CNT_BIT_SIZE-1:0] i_margin,
    input  logic [CNT_BIT_SIZE-1:0] i_cnt_a,
    input  logic                    i_valid_a,
    input  logic [CNT_BIT_SIZE-1:0] i_cnt_b,
    input  logic                    i_valid_b,
    output logic                    o_cnt_clr,
    output logic                    o_cnt_en,
    output logic [IDX_W-1:0]        o_pair_idx,
    output logic [RESP_BITS-1:0]    o_resp,
    output logic [RESP_BITS-1:0]    o_resp_mask,
    output logic                    o_resp_valid,
    input  logic                    i_resp_ready,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam logic [IDX_W-1:0] LastIdx    = IDX_W'(RESP_BITS - 1);
    localparam logic [7:0]       SettleLast = 8'(SETTLE_CYC - 1);

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_BIT_SIZE-1:0] margin_q;
    logic [TMO_W-1:0]        timer_q;
    logic [7:0]              settle_q;
    logic                    cnt_en_q;
    logic [RESP_BITS-1:0]    resp_q;
    logic [RESP_BITS-1:0]    mask_q;
    logic                    resp_valid_q;
    logic                    timeout_q;

    logic                    cap_clr;
    logic                    cap_arm;
    logic [CNT_BIT_SIZE-1:0] cap_a;
    logic [CNT_BIT_SIZE-1:0] cap_b;
    logic                    done_a;
    logic                    done_b;
    logic                    bit_gt;
    logic [CNT_BIT_SIZE-1:0] diff;
    logic                    unstable;

    assign cap_clr = (state_q == StClear);
    assign cap_arm = (state_q == StRun);

    puf_soc_edge_cap #(
        .CNT_BIT_SIZE (CNT_BIT_SIZE)
    ) u_cap_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cap_clr),
        .arm      (cap_arm),
        .valid    (i_valid_a),
        .cnt      (i_cnt_a),
        .cap_val  (cap_a),
        .cap_done (done_a)
    );

    puf_soc_edge_cap #(
        .CNT_BIT_SIZE (CNT_BIT_SIZE)
    ) u_cap_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cap_clr),
        .arm      (cap_arm),
        .valid    (i_valid_b),
        .cnt      (i_cnt_b),
        .cap_val  (cap_b),
        .cap_done (done_b)
    );

    // Unsigned compare and distance between the two captured counts.
    always_comb begin
        bit_gt   = (cap_a > cap_b);
        diff     = bit_gt ? (cap_a - cap_b) : (cap_b - cap_a);
        unstable = (diff < margin_q);
    end

    // Measurement sequencer with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            margin_q     <= '0;
            timer_q      <= '0;
            settle_q     <= '0;
            cnt_en_q     <= 1'b0;
            resp_q       <= '0;
            mask_q       <= '0;
            resp_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        margin_q  <= i_margin;
                        idx_q     <= '0;
                        resp_q    <= '0;
                        mask_q    <= '0;
                        timeout_q <= 1'b0;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    timer_q  <= '0;
                    settle_q <= '0;
                    state_q  <= StSettle;
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        cnt_en_q <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                StRun: begin
                    // A completed pair wins over a timeout in the same cycle.
                    if (done_a && done_b) begin
                        cnt_en_q <= 1'b0;
                        state_q  <= StCmp;
                    end else if (&timer_q) begin
                        cnt_en_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        timer_q <= timer_q + TMO_W'(1);
                    end
                end
                StCmp: begin
                    resp_q[idx_q] <= bit_gt;
                    mask_q[idx_q] <= unstable;
                    if (idx_q == LastIdx) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= StOut;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= StClear;
                    end
                end
                StOut: begin
                    if (i_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_cnt_clr    = (state_q == StClear);
    assign o_cnt_en     = cnt_en_q;
    assign o_pair_idx   = idx_q;
    assign o_resp       = resp_q;
    assign o_resp_mask  = mask_q;
    assign o_resp_valid = resp_valid_q;
    assign o_busy       = (state_q != StIdle);
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_puf_soc_resp_gen.sv
// Scoreboard bench for puf_soc_resp_gen with a 4-bit response and 4-bit timer.
module tb_puf_soc_resp_gen;

    localparam int unsigned CW = 32;
    localparam int unsigned RB = 4;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [RB-1:0] resp;
        logic [RB-1:0] mask;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_margin = '0;
    logic [CW-1:0] i_cnt_a = '0;
    logic          i_valid_a = 1'b0;
    logic [CW-1:0] i_cnt_b = '0;
    logic          i_valid_b = 1'b0;
    logic          i_resp_ready = 1'b0;
    logic          o_cnt_clr;
    logic          o_cnt_en;
    logic [IW-1:0] o_pair_idx;
    logic [RB-1:0] o_resp;
    logic [RB-1:0] o_resp_mask;
    logic          o_resp_valid;
    logic          o_busy;
    logic          o_timeout;

    int   checks = 0;
    int   errors = 0;
    int   clr_cnt = 0;
    int   valid_rises = 0;
    logic valid_prev = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    puf_soc_resp_gen #(
        .CNT_BIT_SIZE (CW),
        .RESP_BITS    (RB),
        .SETTLE_CYC   (4),
        .TMO_W        (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_margin     (i_margin),
        .i_cnt_a      (i_cnt_a),
        .i_valid_a    (i_valid_a),
        .i_cnt_b      (i_cnt_b),
        .i_valid_b    (i_valid_b),
        .o_cnt_clr    (o_cnt_clr),
        .o_cnt_en     (o_cnt_en),
        .o_pair_idx   (o_pair_idx),
        .o_resp       (o_resp),
        .o_resp_mask  (o_resp_mask),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    // Count clear pulses and response-valid rising edges.
    always @(posedge clk) begin
        valid_prev <= o_resp_valid;
        if (o_cnt_clr) clr_cnt <= clr_cnt + 1;
        if (o_resp_valid && !valid_prev) valid_rises <= valid_rises + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: bit = A > B, mask = |A-B| < margin, all unsigned.
    function automatic exp_t model(input logic [CW-1:0] margin,
                                   input logic [RB-1:0][CW-1:0] av,
                                   input logic [RB-1:0][CW-1:0] bv);
        exp_t        e;
        logic [CW-1:0] d;
        for (int i = 0; i < RB; i++) begin
            e.resp[i] = (av[i] > bv[i]);
            d = (av[i] > bv[i]) ? av[i] - bv[i] : bv[i] - av[i];
            e.mask[i] = (d < margin);
        end
        return e;
    endfunction

    task automatic start_run(input logic [CW-1:0] margin);
        i_margin = margin;
        i_start  = 1'b1;
        step();
        i_start  = 1'b0;
        i_margin = '1;
    endtask

    task automatic wait_clr(input int i);
        int n = 0;
        while (!o_cnt_clr && n < 60) begin
            step();
            n++;
        end
        check("clr_seen", 64'(o_cnt_clr), 64'd1);
        check("idx_clear", 64'(o_pair_idx), 64'(i));
    endtask

    task automatic wait_en();
        int n = 0;
        while (!o_cnt_en && n < 20) begin
            step();
            n++;
        end
        check("en_seen", 64'(o_cnt_en), 64'd1);
    endtask

    // One measurement; hold_a keeps a stale high valid_a into RUN.
    task automatic do_bit(input int i, input logic [CW-1:0] a, input logic [CW-1:0] b,
                          input int da, input int db, input bit hold_a);
        wait_clr(i);
        if (!hold_a) i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        wait_en();
        for (int t = 0; t < 30 && o_cnt_en; t++) begin
            if (hold_a) begin
                if (t == 2) i_valid_a = 1'b0;
                if (t == 3) begin
                    i_cnt_a   = a;
                    i_valid_a = 1'b1;
                end
            end else if (t == da) begin
                i_cnt_a   = a;
                i_valid_a = 1'b1;
            end
            if (t == db) begin
                i_cnt_b   = b;
                i_valid_b = 1'b1;
            end
            step();
        end
        check("en_drop", 64'(o_cnt_en), 64'd0);
        check("idx_cmp", 64'(o_pair_idx), 64'(i));
    endtask

    task automatic run_word(input logic [CW-1:0] margin,
                            input logic [RB-1:0][CW-1:0] av,
                            input logic [RB-1:0][CW-1:0] bv,
                            input int hold_bit, input int same_bit, input int ready_wait);
        exp_t e;
        exp_t got;
        int   c0;
        e = model(margin, av, bv);
        sb_q.push_back(e);
        c0 = clr_cnt;
        start_run(margin);
        check("tmo_clear", 64'(o_timeout), 64'd0);
        for (int i = 0; i < RB; i++) begin
            if (i == same_bit) do_bit(i, av[i], bv[i], 1, 1, 1'b0);
            else do_bit(i, av[i], bv[i], i % 3, (i + 1) % 3, i == hold_bit);
        end
        check("valid_at_cmp", 64'(o_resp_valid), 64'd0);
        step();
        check("valid_latency", 64'(o_resp_valid), 64'd1);
        check("clr_pulses", 64'(clr_cnt - c0), 64'(RB));
        for (int k = 0; k < ready_wait; k++) begin
            check("hold_valid", 64'(o_resp_valid), 64'd1);
            check("hold_resp", 64'({o_resp, o_resp_mask}), 64'(e));
            step();
        end
        i_resp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            check("resp", 64'(o_resp), 64'(got.resp));
            check("mask", 64'(o_resp_mask), 64'(got.mask));
        end
        step();
        i_resp_ready = 1'b0;
        check("valid_drop", 64'(o_resp_valid), 64'd0);
        check("busy_idle", 64'(o_busy), 64'd0);
        check("resp_after", 64'({o_resp, o_resp_mask}), 64'(e));
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({o_cnt_clr, o_cnt_en, o_pair_idx, o_resp, o_resp_mask,
                        o_resp_valid, o_busy, o_timeout}), 64'd0);
    endtask

    initial begin
        int n;
        int vr0;

        // Reset state, during and after reset.
        step();
        check_all_zero("reset_hold");
        step();
        rst_n = 1'b1;
        step();
        check_all_zero("reset_release");

        // Bit 3 .. bit 0 in each concatenation.
        run_word(32'd0, {32'd200, 32'd7, 32'd50, 32'd100}, {32'd1, 32'd7, 32'd60, 32'd90},
                 -1, -1, 0);
        run_word(32'd16, {32'd0, 32'd5, 32'd100, 32'd100}, {32'd17, 32'd5, 32'd120, 32'd90},
                 -1, -1, 10);

        // Counter B never reports: timeout, no response.
        vr0 = valid_rises;
        start_run(32'd0);
        wait_clr(0);
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        wait_en();
        n = 0;
        while (!o_timeout && n < 40) begin
            if (n == 1) begin
                i_cnt_a   = 32'd42;
                i_valid_a = 1'b1;
            end
            step();
            n++;
        end
        check("tmo_flag", 64'(o_timeout), 64'd1);
        check("tmo_bound", 64'(n >= 15 && n <= 17), 64'd1);
        check("tmo_busy", 64'(o_busy), 64'd0);
        check("tmo_en", 64'(o_cnt_en), 64'd0);
        step();
        step();
        check("tmo_sticky", 64'(o_timeout), 64'd1);
        check("tmo_no_valid", 64'(valid_rises), 64'(vr0));

        // Stale valid_a across bits 0->1, simultaneous edges on bit 2.
        run_word(32'd8, {32'd3, 32'd77, 32'd5, 32'd500}, {32'd9, 32'd70, 32'd20, 32'd10},
                 1, 2, 0);

        // Reset during RUN of bit 2 aborts with everything cleared.
        vr0 = valid_rises;
        start_run(32'd0);
        do_bit(0, 32'd10, 32'd20, 0, 1, 1'b0);
        do_bit(1, 32'd30, 32'd20, 1, 0, 1'b0);
        wait_clr(2);
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        wait_en();
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_run");
        check("reset_no_valid", 64'(valid_rises), 64'(vr0));
        i_valid_a = 1'b0;
        i_valid_b = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        run_word(32'd0, {32'd200, 32'd7, 32'd50, 32'd100}, {32'd1, 32'd7, 32'd60, 32'd90},
                 -1, -1, 0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/puf_soc_resp_gen.md
Name: puf_soc_resp_gen

Overview:
- Downstream consumer of a pair of PUF ring-oscillator counter instances (counter A and counter B).
- Sequences one measurement per response bit: clear counters, enable counting, wait for both counts, compare, record bit.
- Assembles RESP_BITS bits into a response word plus an instability mask, then hands the word to the SoC register interface via valid/ready.

Parameters:
- CNT_BIT_SIZE, 32, width of counter values; must match the counter instances.
- RESP_BITS, 16, response bits per run; IDX_W = clog2(RESP_BITS) as a localparam, minimum 1.
- SETTLE_CYC, 4, cycles waited after counter clear before enabling; range 1..255.
- TMO_W, 24, timeout timer width; timeout fires when the timer reaches all-ones.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  pulse; starts a run. Ignored unless in IDLE.
- i_margin  in  CNT_BIT_SIZE  stability margin; sampled on the accepted i_start.
- i_cnt_a  in  CNT_BIT_SIZE  counter A value.
- i_valid_a  in  1  counter A valid; level signal, may stay high many cycles.
- i_cnt_b  in  CNT_BIT_SIZE  counter B value.
- i_valid_b  in  1  counter B valid; level signal, may stay high many cycles.
- o_cnt_clr  out  1  one-cycle clear request to the counter pair; integration routes it through the counters' reset synchroniser.
- o_cnt_en  out  1  count enable to both counters.
- o_pair_idx  out  IDX_W  index of the RO pair currently selected (the upstream RO mux select).
- o_resp  out  RESP_BITS  response word; bit i = result for pair i.
- o_resp_mask  out  RESP_BITS  bit i = 1 if pair i is unstable (|A-B| < margin).
- o_resp_valid  out  1  response available.
- i_resp_ready  in  1  consumer accepts the response.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  sticky error flag; cleared by the next accepted i_start.

Behaviour:
- Reset values: all outputs 0, state IDLE, idx 0, capture flags 0, timer 0.
- Reset mid-run aborts immediately. No partial response is ever presented.
- States:
  - IDLE: on i_start → CLEAR. Latch i_margin, idx=0, clear o_resp/o_resp_mask/o_timeout.
  - CLEAR: o_cnt_clr=1 for exactly one cycle. Reset capture flags and timer → SETTLE.
  - SETTLE: wait SETTLE_CYC cycles with o_cnt_en=0 → RUN.
  - RUN: o_cnt_en=1, timer increments each cycle.
    - Both captured → CMP (o_cnt_en drops the same cycle the second capture registers).
    - Timer all-ones with either count missing → o_timeout=1 → IDLE, no response.
  - CMP: one cycle.
    - bit = (capA > capB); mask = (|capA-capB| < margin), computed on unsigned CNT_BIT_SIZE values.
    - Write both into position idx.
    - If idx == RESP_BITS-1 → OUT; else idx++ → CLEAR.
  - OUT: o_resp_valid=1, held with stable data until i_resp_ready is sampled high. Then o_resp_valid=0 → IDLE.
- Capture rules:
  - Each channel captures its count on the rising edge of its valid (registered previous valid) while in RUN.
  - Further edges are ignored until the next CLEAR.
  - A valid already high on entry to RUN is not an edge. This guards against stale data from the previous bit.
  - A and B capturing in the same cycle is legal.
- Tie (A==B): bit=0. Mask=1 iff margin>0. With margin=0 the mask is always 0.
- o_pair_idx = idx. Stable from CLEAR through CMP of each bit.
- Latency: o_resp_valid rises the cycle after the final CMP. o_resp and o_resp_mask hold after the handshake until the next i_start.
- i_start while busy is ignored, with no side effects.

Decomposition:
- Shared package puf_soc_pkg: state enum (IDLE, CLEAR, SETTLE, RUN, CMP, OUT), default CNT_BIT_SIZE and RESP_BITS constants.
- One sub-module, puf_soc_edge_cap, instantiated twice (A and B):
  - Inputs: clk, rst_n, clr, arm, valid, cnt.
  - Outputs: cap_val, cap_done.
  - Behaviour: rising-edge detect plus count capture register.

Test Plan:
- RESP_BITS=4, margin=0. Per-bit counts (A,B) = (100,90), (50,60), (7,7), (200,1) → o_resp=4'b1001, o_resp_mask=4'b0000. o_resp_valid one cycle after the 4th CMP. Exactly 4 o_cnt_clr pulses; o_pair_idx steps 0,1,2,3.
- Margin=16, counts (100,90), (100,120), (5,5), (0,17) → o_resp=4'b0001, o_resp_mask=4'b0101.
- Hold i_resp_ready=0 for 10 cycles in OUT → o_resp_valid and data stable throughout. Ready=1 → valid drops next cycle, state IDLE, o_busy=0.
- Counter B never asserts valid, TMO_W=4 → o_timeout=1 after 15 RUN cycles, return to IDLE, o_resp_valid never rises. Next i_start clears o_timeout.
- i_valid_a held high from the previous bit into RUN → no capture until it falls and rises again. A and B rising in the same cycle → single CMP with correct bit.
- rst_n asserted during RUN of bit 2 → all outputs 0 immediately. A fresh i_start after release produces a full, correct word.
